// File: rtl/mem_access_sequencer_if.sv
// Request/memory bus of the MIPS load/store sequencer.
// Request side : req_valid/req_ready handshake with opcode, byte address, store data.
// Memory side  : word address, one-cycle read/write strobes, write word, read word.
// Completion   : done pulse qualified by err, sign-extended load_data.
// master = pipeline + memory (drives requests and read data); slave = sequencer.
interface mem_access_sequencer_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_opcode;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              done;
    logic              err;
    logic [31:0]       load_data;

    modport master (
        output req_valid, req_opcode, req_addr, req_wdata, mem_rdata,
        input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err, load_data
    );

    modport slave (
        input  req_valid, req_opcode, req_addr, req_wdata, mem_rdata,
        output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err, load_data
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Sequences MIPS word/half/byte loads and stores onto a word-wide memory.
// Sub-word stores are done as read-modify-write; loads are sign-extended.
// Ports: Clk, Reset (async, active-high), bus (mem_access_sequencer_if.slave).
// Every bus output is registered; request fields are captured on accept.
module mem_access_sequencer #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                   Clk,
    input  logic                   Reset,
    mem_access_sequencer_if.slave  bus
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 6;

    localparam logic [OP_W-1:0] OP_LB = 6'b100000;
    localparam logic [OP_W-1:0] OP_LH = 6'b100001;
    localparam logic [OP_W-1:0] OP_LW = 6'b100011;
    localparam logic [OP_W-1:0] OP_SB = 6'b101000;
    localparam logic [OP_W-1:0] OP_SH = 6'b101001;
    localparam logic [OP_W-1:0] OP_SW = 6'b101011;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [OP_W-1:0]     op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   word_buf_q, word_buf_d;

    logic                ready_q, ready_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;

    logic                accept;
    logic [OP_W-1:0]     cur_op;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic [ADDR_W-1:0]   aligned_addr;
    logic [1:0]          lane;
    logic                is_w, is_h, is_b, is_store, supported, misaligned;

    // Sign-extended load result from a word, by size and lane.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                      input logic [1:0] ln,
                                                      input logic h, input logic b);
        logic [15:0] hv;
        logic [7:0]  bv;
        hv = ln[1] ? word[31:16] : word[15:0];
        if (ln == 2'd0)      bv = word[7:0];
        else if (ln == 2'd1) bv = word[15:8];
        else if (ln == 2'd2) bv = word[23:16];
        else                 bv = word[31:24];
        if (b)      return {{24{bv[7]}}, bv};
        else if (h) return {{16{hv[15]}}, hv};
        else        return word;
    endfunction

    // Word with the selected half or byte lane replaced by the store data.
    function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] word,
                                                      input logic [15:0] data,
                                                      input logic [1:0] ln,
                                                      input logic h);
        logic [DATA_W-1:0] r;
        r = word;
        if (h) begin
            if (ln[1]) r[31:16] = data;
            else       r[15:0]  = data;
        end else begin
            if (ln == 2'd0)      r[7:0]   = data[7:0];
            else if (ln == 2'd1) r[15:8]  = data[7:0];
            else if (ln == 2'd2) r[23:16] = data[7:0];
            else                 r[31:24] = data[7:0];
        end
        return r;
    endfunction

    // In IDLE the request is still on the bus; afterwards use the captured copy.
    always_comb begin
        cur_op    = (state_q == IDLE) ? bus.req_opcode : op_q;
        cur_addr  = (state_q == IDLE) ? bus.req_addr   : addr_q;
        cur_wdata = (state_q == IDLE) ? bus.req_wdata  : wdata_q;
    end

    // Opcode decode and alignment check.
    always_comb begin
        is_w      = 1'b0;
        is_h      = 1'b0;
        is_b      = 1'b0;
        is_store  = 1'b0;
        supported = 1'b1;
        case (cur_op)
            OP_LW:   is_w = 1'b1;
            OP_LH:   is_h = 1'b1;
            OP_LB:   is_b = 1'b1;
            OP_SW:   begin is_w = 1'b1; is_store = 1'b1; end
            OP_SH:   begin is_h = 1'b1; is_store = 1'b1; end
            OP_SB:   begin is_b = 1'b1; is_store = 1'b1; end
            default: supported = 1'b0;
        endcase
        lane         = cur_addr[1:0];
        misaligned   = (is_w && (lane != 2'd0)) || (is_h && lane[0]);
        aligned_addr = {cur_addr[ADDR_W-1:2], 2'b00};
        accept       = (state_q == IDLE) && ready_q && bus.req_valid;
    end

    // Read data is bypassed into the buffer's next value so merge/extend see it in CAPTURE.
    assign word_buf_d = (state_q == CAPTURE) ? bus.mem_rdata : word_buf_q;

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        load_data_d = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!supported || misaligned) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (cur_op == OP_SW) begin
                        state_d     = WRITE;
                        wr_en_d     = 1'b1;
                        mem_addr_d  = aligned_addr;
                        mem_wdata_d = cur_wdata;
                    end else begin
                        state_d    = READ;
                        rd_en_d    = 1'b1;
                        mem_addr_d = aligned_addr;
                    end
                end
            end
            READ: begin
                state_d    = CAPTURE;
                mem_addr_d = aligned_addr;
            end
            CAPTURE: begin
                if (is_store) begin
                    state_d     = WRITE;
                    wr_en_d     = 1'b1;
                    mem_addr_d  = aligned_addr;
                    mem_wdata_d = store_merge(word_buf_d, cur_wdata[15:0], lane, is_h);
                end else begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    load_data_d = load_extend(word_buf_d, lane, is_h, is_b);
                end
            end
            WRITE: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // State, request capture and output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            word_buf_q  <= '0;
            ready_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            word_buf_q  <= word_buf_d;
            ready_q     <= ready_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            load_data_q <= load_data_d;
            if (accept) begin
                op_q    <= bus.req_opcode;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.mem_rd_en = rd_en_q;
    assign bus.mem_wr_en = wr_en_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.load_data = load_data_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: vector table through a scoreboard,
// plus hand-written reset sequences.
module tb_mem_access_sequencer;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned NVEC   = 15;

    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_LH = 6'b100001;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    // Offsets are cycles after the accept cycle; 0 means the strobe must not occur.
    typedef struct {
        int          idx;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        logic        err;
        logic [31:0] load;
        logic [31:0] mwdata;
        int          rd_off;
        int          wr_off;
        int          done_off;
        int          acc;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] mem_word;
    logic        rd_seen = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    vec_t vecs [NVEC];
    vec_t sb [$];

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          rd_off = 0;
    int          wr_off = 0;
    logic [31:0] wr_data = '0;
    bit          ready_chk = 1'b0;

    mem_access_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_sequencer #(.ADDR_W(ADDR_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    // Memory model: read word is valid in the cycle after mem_rd_en, garbage otherwise.
    always @(negedge Clk) begin
        bus.mem_rdata = rd_seen ? mem_word : 32'h5A5A_5A5A;
        rd_seen       = bus.mem_rd_en;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: collects strobes of the transaction in flight, scores it on done.
    always @(negedge Clk) begin
        int   offs;
        vec_t e;
        if (Reset) begin
            rd_cnt    = 0;
            wr_cnt    = 0;
            ready_chk = 1'b0;
        end else begin
            offs = (sb.size() != 0) ? cyc - sb[0].acc : 0;
            if (ready_chk) begin
                chk("ready_after_done", 32'(bus.req_ready), 32'd1);
                ready_chk = 1'b0;
            end
            if (bus.done !== 1'b1)
                chk("load_data_not_done", bus.load_data, 32'd0);
            if (bus.mem_rd_en === 1'b1) begin
                if (sb.size() == 0) chk("unexpected_rd", 32'd1, 32'd0);
                else begin
                    rd_cnt++;
                    rd_off = offs;
                    chk($sformatf("v%0d_rd_addr", sb[0].idx), bus.mem_addr, {sb[0].addr[31:2], 2'b00});
                end
            end
            if (bus.mem_wr_en === 1'b1) begin
                if (sb.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
                else begin
                    wr_cnt++;
                    wr_off  = offs;
                    wr_data = bus.mem_wdata;
                    chk($sformatf("v%0d_wr_addr", sb[0].idx), bus.mem_addr, {sb[0].addr[31:2], 2'b00});
                end
            end
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d_done_off", e.idx), 32'(offs), 32'(e.done_off));
                    chk($sformatf("v%0d_err", e.idx), 32'(bus.err), 32'(e.err));
                    chk($sformatf("v%0d_load_data", e.idx), bus.load_data, e.load);
                    chk($sformatf("v%0d_ready_in_done", e.idx), 32'(bus.req_ready), 32'd0);
                    chk($sformatf("v%0d_rd_cnt", e.idx), 32'(rd_cnt), (e.rd_off != 0) ? 32'd1 : 32'd0);
                    if (e.rd_off != 0)
                        chk($sformatf("v%0d_rd_off", e.idx), 32'(rd_off), 32'(e.rd_off));
                    chk($sformatf("v%0d_wr_cnt", e.idx), 32'(wr_cnt), (e.wr_off != 0) ? 32'd1 : 32'd0);
                    if (e.wr_off != 0) begin
                        chk($sformatf("v%0d_wr_off", e.idx), 32'(wr_off), 32'(e.wr_off));
                        chk($sformatf("v%0d_wr_data", e.idx), wr_data, e.mwdata);
                    end
                    ready_chk = 1'b1;
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_mem_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
        chk({tag, "_mem_wr_en"}, 32'(bus.mem_wr_en), 32'd0);
        chk({tag, "_done"},      32'(bus.done), 32'd0);
        chk({tag, "_err"},       32'(bus.err), 32'd0);
        chk({tag, "_mem_addr"},  bus.mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_load_data"}, bus.load_data, 32'd0);
    endtask

    // Waits for req_ready, presents one request, pushes its expectation.
    task automatic issue(input vec_t v_in, output bit ok);
        vec_t v;
        int   n;
        v  = v_in;
        n  = 0;
        ok = 1'b0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge Clk); #1;
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            chk($sformatf("v%0d_ready_timeout", v.idx), 32'd0, 32'd1);
            return;
        end
        mem_word       = v.word;
        bus.req_opcode = v.op;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        bus.req_valid  = 1'b1;
        v.acc          = cyc;
        sb.push_back(v);
        @(negedge Clk); #1;
        // Scramble the bus so only the captured request fields can be used.
        bus.req_valid  = 1'b0;
        bus.req_opcode = 6'b000000;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_wdata  = 32'hFFFF_FFFF;
        ok = 1'b1;
    endtask

    task automatic run_vec(input int i);
        bit ok;
        int n;
        issue(vecs[i], ok);
        if (!ok) return;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge Clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk($sformatf("v%0d_done_timeout", i), 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic set_vec(input int i, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] word, input logic err,
                           input logic [31:0] load, input logic [31:0] mwdata,
                           input int rdo, input int wro, input int dno);
        vecs[i] = '{i, op, addr, wdata, word, err, load, mwdata, rdo, wro, dno, 0};
    endtask

    initial begin
        vec_t rv;
        bit   ok;
        bit   bad_strobe;

        Reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_opcode = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        mem_word       = '0;

        //      idx op     addr       wdata         word          err  load          mwdata     rd wr dn
        set_vec(0,  OP_LB, 32'h102,   32'h0,        32'h80FF7F01, 0, 32'hFFFFFFFF, 32'h0,       1, 0, 3);
        set_vec(1,  OP_LB, 32'h103,   32'h0,        32'h80FF7F01, 0, 32'hFFFFFF80, 32'h0,       1, 0, 3);
        set_vec(2,  OP_LB, 32'h101,   32'h0,        32'h80FF7F01, 0, 32'h0000007F, 32'h0,       1, 0, 3);
        set_vec(3,  OP_SB, 32'h201,   32'h000000AA, 32'h11223344, 0, 32'h0,        32'h1122AA44, 1, 3, 4);
        set_vec(4,  OP_SH, 32'h302,   32'h00001234, 32'hDEADBEEF, 0, 32'h0,        32'h1234BEEF, 1, 3, 4);
        set_vec(5,  OP_LH, 32'h302,   32'h0,        32'h80015555, 0, 32'hFFFF8001, 32'h0,       1, 0, 3);
        set_vec(6,  OP_LH, 32'h300,   32'h0,        32'h80017FFE, 0, 32'h00007FFE, 32'h0,       1, 0, 3);
        set_vec(7,  OP_LW, 32'h104,   32'h0,        32'h12345678, 0, 32'h12345678, 32'h0,       1, 0, 3);
        set_vec(8,  OP_SW, 32'h40,    32'hCAFEF00D, 32'h0,        0, 32'h0,        32'hCAFEF00D, 0, 1, 2);
        set_vec(9,  OP_LW, 32'h41,    32'h0,        32'h0,        1, 32'h0,        32'h0,       0, 0, 1);
        set_vec(10, 6'b000000, 32'h0, 32'h0,        32'h0,        1, 32'h0,        32'h0,       0, 0, 1);
        set_vec(11, OP_SH, 32'h301,   32'h00001234, 32'h0,        1, 32'h0,        32'h0,       0, 0, 1);
        set_vec(12, OP_SW, 32'h42,    32'h12345678, 32'h0,        1, 32'h0,        32'h0,       0, 0, 1);
        set_vec(13, OP_SB, 32'h203,   32'h12345677, 32'h11223344, 0, 32'h0,        32'h77223344, 1, 3, 4);
        set_vec(14, OP_LH, 32'h303,   32'h0,        32'h0,        1, 32'h0,        32'h0,       0, 0, 1);

        // Power-on reset values and first ready edge.
        repeat (2) @(negedge Clk);
        #1;
        check_all_zero("por");
        Reset = 1'b0;
        #1;
        chk("por_ready_before_edge", 32'(bus.req_ready), 32'd0);
        @(posedge Clk); #1;
        chk("por_ready_first_edge", 32'(bus.req_ready), 32'd1);
        @(negedge Clk); #1;

        for (int i = 0; i < int'(NVEC); i++) run_vec(i);

        // Reset in CAPTURE of an SB: nothing may complete afterwards.
        rv = '{100, OP_SB, 32'h201, 32'h000000AA, 32'h11223344, 1'b0, 32'h0, 32'h1122AA44, 1, 3, 4, 0};
        issue(rv, ok);
        if (ok) begin
            chk("rst_seq_rd_en", 32'(bus.mem_rd_en), 32'd1);
            @(negedge Clk); #1;
            Reset = 1'b1;
            sb.delete();
            #1;
            check_all_zero("midop");
            repeat (2) @(negedge Clk);
            #1;
            Reset = 1'b0;
            #1;
            chk("midop_ready_before_edge", 32'(bus.req_ready), 32'd0);
            @(posedge Clk); #1;
            chk("midop_ready_first_edge", 32'(bus.req_ready), 32'd1);
            bad_strobe = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge Clk); #1;
                if (bus.mem_wr_en !== 1'b0 || bus.done !== 1'b0 || bus.mem_rd_en !== 1'b0)
                    bad_strobe = 1'b1;
            end
            chk("midop_no_resume", 32'(bad_strobe), 32'd0);
        end

        // Sequencer still works after the aborted request.
        run_vec(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of req_addr and mem_addr.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: Clk (input, 1) is the single clock; Reset (input, 1) is asynchronous and active-high.
REQ-003 SHALL have port req_valid, input, 1: pipeline requests a memory operation.
REQ-004 SHALL have port req_ready, output, 1: sequencer can accept a request.
REQ-005 SHALL have port req_opcode, input, 6: MIPS opcode (LW 100011, SW 101011, LH 100001, SH 101001, LB 100000, SB 101000).
REQ-006 SHALL have port req_addr, input, ADDR_W: byte address.
REQ-007 SHALL have port req_wdata, input, 32: Rt store data, with the sub-word in bits [15:0] or [7:0].
REQ-008 SHALL have port mem_addr, output, ADDR_W: word-aligned address, {req_addr[ADDR_W-1:2],2'b00}.
REQ-009 SHALL have port mem_rd_en, output, 1: word read strobe.
REQ-010 SHALL have port mem_wr_en, output, 1: word write strobe.
REQ-011 SHALL have port mem_wdata, output, 32: full word to write.
REQ-012 SHALL have port mem_rdata, input, 32: read word, valid exactly one cycle after mem_rd_en.
REQ-013 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port err, output, 1: qualifies done; the request was misaligned or unsupported.
REQ-015 SHALL have port load_data, output, 32: sign-extended load result, valid while done=1 for a load.

Function
REQ-016 SHALL implement states IDLE, READ, CAPTURE, WRITE, DONE as a Moore FSM with registered request fields (opcode, addr, wdata).
REQ-017 SHALL drive req_ready=1 only in IDLE, and accept a request only when req_valid=1 in IDLE; req_valid in any other state SHALL be ignored.
REQ-018 SHALL take transitions per request type:
- LW/LH/LB: IDLE->READ->CAPTURE->DONE->IDLE; done at accept+3.
- SH/SB: IDLE->READ->CAPTURE->WRITE->DONE->IDLE; done at accept+4.
- SW: IDLE->WRITE->DONE->IDLE; done at accept+2.
REQ-019 SHALL go IDLE->DONE->IDLE with err=1 for misaligned requests (LW/SW with addr[1:0]!=0; LH/SH with addr[0]=1) and unsupported opcodes, issuing no memory strobe.
REQ-020 SHALL drive mem_rd_en=1 only in READ and mem_wr_en=1 only in WRITE, each for exactly one cycle per request.
REQ-021 SHALL register mem_rdata into an internal word buffer in CAPTURE.
REQ-022 SHALL use little-endian lanes: byte lane = addr[1:0] (00 -> bits [7:0], 11 -> bits [31:24]); half lane = addr[1] (0 -> [15:0], 1 -> [31:16]).
REQ-023 SHALL form mem_wdata in WRITE as follows:
- SW: req_wdata.
- SH: buffered word with the selected half replaced by req_wdata[15:0].
- SB: buffered word with the selected byte replaced by req_wdata[7:0].
REQ-024 SHALL form load_data as follows:
- LW: buffered word.
- LH: the selected half, sign-extended to 32 bits.
- LB: the selected byte, sign-extended to 32 bits.
REQ-025 SHALL drive load_data=0 when done=0 or the request is a store or an error.
REQ-026 SHALL hold mem_addr at the aligned request address from READ through WRITE, and at 0 in IDLE.
REQ-027 SHALL accept a new request in the cycle after DONE (back-to-back), with no bubble beyond the DONE cycle.

Reset
REQ-028 SHALL, on Reset=1 at any time (asynchronously), enter IDLE and clear req_ready, mem_rd_en, mem_wr_en, done, err, mem_addr, mem_wdata, load_data and the buffer to 0.
REQ-029 SHALL drive req_ready=1 from the first clock edge after reset deasserts.
REQ-030 SHALL NOT, after reset mid-operation, complete or resume the aborted request: no write, no done.

Verification
REQ-031 SHALL verify LB sign-extension: mem word 0x80FF7F01, LB at addr 0x102 -> mem_rd_en at accept+1 with mem_addr 0x100; done at accept+3 with load_data 0xFFFFFFFF; LB at 0x103 -> load_data 0xFFFFFF80.
REQ-032 SHALL verify SB read-modify-write: mem word 0x11223344, SB addr 0x201, req_wdata 0x000000AA -> read at accept+1, mem_wr_en at accept+3 with mem_wdata 0x1122AA44, done at accept+4.
REQ-033 SHALL verify SH upper half: mem word 0xDEADBEEF, SH addr 0x302, req_wdata 0x00001234 -> mem_wdata 0x1234BEEF; LH at 0x302 of 0x8001xxxx -> load_data 0xFFFF8001.
REQ-034 SHALL verify SW: SW addr 0x40, req_wdata 0xCAFEF00D -> no mem_rd_en; mem_wr_en at accept+1 with mem_wdata 0xCAFEF00D; done at accept+2; next request accepted at accept+3.
REQ-035 SHALL verify errors: LW at 0x41 and opcode 000000 -> done=1 and err=1 at accept+1, no mem strobe.
REQ-036 SHALL verify reset mid-operation: SB accepted, Reset asserted in CAPTURE -> all outputs 0 immediately; no mem_wr_en and no done afterwards; req_ready=1 on the first edge after release.
